// File: rtl/wb_serializer_fifo.sv
// Wishbone slave that queues N_SYMB x SYMB_W words in a TX FIFO and streams them
// out serially, MSB- or LSB-first, with a programmable bit period.
module wb_serializer_fifo #(
  parameter int unsigned SYMB_W    = 9,
  parameter int unsigned N_SYMB    = 3,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned DIV_W     = 8,
  parameter int unsigned ADDR_SIZE = 4
) (
  input  logic        CLK_I,
  input  logic        RST_I,
  input  logic        CYC_I,
  input  logic        STB_I,
  input  logic        WE_I,
  input  logic [31:0] ADR_I,
  input  logic [31:0] DAT_I,
  output logic [31:0] DAT_O,
  output logic        ACK_O,
  output logic        ERR_O,
  output logic        data_o,
  output logic        valid_o,
  output logic        frame_o,
  output logic        busy_o,
  output logic        irq_o
);

  localparam int unsigned WORD_W = SYMB_W * N_SYMB;
  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned LVL_W  = PTR_W + 1;
  localparam int unsigned CNT_W  = $clog2(WORD_W + 1);

  typedef enum logic {ST_IDLE = 1'b0, ST_SHIFT = 1'b1} state_e;

  logic [ADDR_SIZE-1:0] adr_c;
  logic req_c, legal_c, wr_c, push_req_c, push_c, pop_c, clr_c, load_c;
  logic sel_data_c, sel_stat_c, sel_ctrl_c, sel_div_c;
  logic en_q, lsb_first_q, irq_en_q, ovf_q;
  logic [DIV_W-1:0]  div_q;
  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [LVL_W-1:0]  wr_ptr_q, rd_ptr_q, level_c;
  logic              empty_c, full_c;
  logic [WORD_W-1:0] head_c, rev_c;

  state_e            state_q, state_d;
  logic [WORD_W-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]  bitcnt_q, bitcnt_d;
  logic [DIV_W-1:0]  baud_q, baud_d;
  logic              frame_q, frame_d;

  logic unused_c;
  assign unused_c = ^{ADR_I, DAT_I};

  // Bus decode: DATA is write-only, the other three registers are R/W.
  assign adr_c      = ADR_I[ADDR_SIZE-1:0];
  assign sel_data_c = (adr_c == ADDR_SIZE'(32'h0));
  assign sel_stat_c = (adr_c == ADDR_SIZE'(32'h4));
  assign sel_ctrl_c = (adr_c == ADDR_SIZE'(32'h8));
  assign sel_div_c  = (adr_c == ADDR_SIZE'(32'hC));
  assign req_c      = CYC_I & STB_I;
  assign legal_c    = sel_stat_c | sel_ctrl_c | sel_div_c | (sel_data_c & WE_I);
  assign ACK_O      = req_c & legal_c;
  assign ERR_O      = req_c & ~legal_c;
  assign wr_c       = ACK_O & WE_I;
  assign push_req_c = wr_c & sel_data_c;
  assign clr_c      = wr_c & sel_ctrl_c & DAT_I[2];

  assign level_c = wr_ptr_q - rd_ptr_q;
  assign empty_c = (level_c == '0);
  assign full_c  = (level_c == LVL_W'(DEPTH));
  assign push_c  = push_req_c & (~full_c | pop_c);
  assign head_c  = mem_q[rd_ptr_q[PTR_W-1:0]];

  always_comb begin : read_mux
    DAT_O = '0;
    if (ACK_O && !WE_I) begin
      if (sel_stat_c)      DAT_O = {16'h0, 8'(level_c), 4'h0, ovf_q, full_c, empty_c, busy_o};
      else if (sel_ctrl_c) DAT_O = {28'h0, irq_en_q, 1'b0, lsb_first_q, en_q};
      else if (sel_div_c)  DAT_O = 32'(div_q);
    end
  end

  always_ff @(posedge CLK_I or posedge RST_I) begin : csr_regs
    if (RST_I) begin
      en_q        <= 1'b0;
      lsb_first_q <= 1'b0;
      irq_en_q    <= 1'b0;
      div_q       <= '0;
      ovf_q       <= 1'b0;
    end else begin
      if (wr_c && sel_ctrl_c) begin
        en_q        <= DAT_I[0];
        lsb_first_q <= DAT_I[1];
        irq_en_q    <= DAT_I[3];
      end
      if (wr_c && sel_div_c) div_q <= DAT_I[DIV_W-1:0];
      if (push_req_c && full_c && !pop_c)      ovf_q <= 1'b1;
      else if (wr_c && sel_stat_c && DAT_I[3]) ovf_q <= 1'b0;
    end
  end

  always_ff @(posedge CLK_I or posedge RST_I) begin : fifo_ptrs
    if (RST_I) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (clr_c) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_c) wr_ptr_q <= wr_ptr_q + LVL_W'(1);
      if (pop_c)  rd_ptr_q <= rd_ptr_q + LVL_W'(1);
    end
  end

  always_ff @(posedge CLK_I) begin : fifo_mem
    if (push_c) mem_q[wr_ptr_q[PTR_W-1:0]] <= DAT_I[WORD_W-1:0];
  end

  // LSB-first words are reversed at load so the output bit is always the MSB.
  always_comb begin : bit_reverse
    rev_c = '0;
    for (int i = 0; i < int'(WORD_W); i++) rev_c[i] = head_c[int'(WORD_W) - 1 - i];
  end

  always_comb begin : fsm_next
    state_d  = state_q;
    shreg_d  = shreg_q;
    bitcnt_d = bitcnt_q;
    baud_d   = baud_q;
    frame_d  = frame_q;
    load_c   = 1'b0;
    pop_c    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (en_q && !empty_c) load_c = 1'b1;
      end
      ST_SHIFT: begin
        if (baud_q != '0) begin
          baud_d = baud_q - DIV_W'(1);
        end else if (bitcnt_q != '0) begin
          shreg_d  = {shreg_q[WORD_W-2:0], 1'b0};
          bitcnt_d = bitcnt_q - CNT_W'(1);
          baud_d   = div_q;
          frame_d  = 1'b0;
        end else if (en_q && !empty_c) begin
          load_c = 1'b1;
        end else begin
          state_d = ST_IDLE;
          shreg_d = '0;
          frame_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (load_c) begin
      pop_c    = 1'b1;
      state_d  = ST_SHIFT;
      shreg_d  = lsb_first_q ? rev_c : head_c;
      bitcnt_d = CNT_W'(WORD_W - 1);
      baud_d   = div_q;
      frame_d  = 1'b1;
    end
    // A clear aborts everything in flight, including a pop on this edge.
    if (clr_c) begin
      pop_c    = 1'b0;
      state_d  = ST_IDLE;
      shreg_d  = '0;
      bitcnt_d = '0;
      baud_d   = '0;
      frame_d  = 1'b0;
    end
  end

  always_ff @(posedge CLK_I or posedge RST_I) begin : fsm_regs
    if (RST_I) begin
      state_q  <= ST_IDLE;
      shreg_q  <= '0;
      bitcnt_q <= '0;
      baud_q   <= '0;
      frame_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      bitcnt_q <= bitcnt_d;
      baud_q   <= baud_d;
      frame_q  <= frame_d;
    end
  end

  assign data_o  = shreg_q[WORD_W-1];
  assign valid_o = (state_q == ST_SHIFT);
  assign busy_o  = (state_q == ST_SHIFT);
  assign frame_o = frame_q;
  assign irq_o   = irq_en_q & empty_c & (state_q == ST_IDLE);

endmodule

// File: tb/tb_wb_serializer_fifo.sv
// Directed bench for wb_serializer_fifo: register access, MSB/LSB streaming,
// FIFO full/overflow, back-to-back words, clear, async reset and irq.
module tb_wb_serializer_fifo;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [31:0] adr = '0, dat_w = '0;
  logic [31:0] dat_r;
  logic        ack, err, sdata, svalid, sframe, sbusy, sirq;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc_cnt = 0;
  bit bits_q[$];
  int vcyc_q[$];
  int fcyc_q[$];

  always #5 clk = ~clk;

  wb_serializer_fifo dut (
    .CLK_I(clk), .RST_I(rst), .CYC_I(cyc), .STB_I(stb), .WE_I(we),
    .ADR_I(adr), .DAT_I(dat_w), .DAT_O(dat_r), .ACK_O(ack), .ERR_O(err),
    .data_o(sdata), .valid_o(svalid), .frame_o(sframe), .busy_o(sbusy), .irq_o(sirq)
  );

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Serial monitor: records every valid bit with the cycle it was seen in.
  always @(posedge clk) begin
    #2;
    if (svalid === 1'b1) begin
      bits_q.push_back(sdata);
      vcyc_q.push_back(cyc_cnt);
      if (sframe === 1'b1) fcyc_q.push_back(cyc_cnt);
    end
  end

  task automatic clear_mon();
    bits_q.delete();
    vcyc_q.delete();
    fcyc_q.delete();
  endtask

  task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                      output logic [31:0] rd, output logic k, output logic e);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_w = d;
    #1;
    rd = dat_r; k = ack; e = err;
    @(posedge clk);
    #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  function automatic logic [26:0] word_at(int base, int step);
    logic [26:0] w;
    w = '0;
    for (int i = 0; i < 27; i++)
      w = {w[25:0], (base + i * step < bits_q.size()) ? bits_q[base + i * step] : 1'b0};
    return w;
  endfunction

  task automatic test_reset();
    logic [31:0] rd; logic k, e;
    rst = 1'b1;
    #1;
    n_tests++;
    if ({sdata, svalid, sframe, sbusy, sirq} !== 5'b0) begin
      n_fail++; $display("FAIL reset_outputs: got %b expected 00000", {sdata, svalid, sframe, sbusy, sirq});
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    xfer(1'b0, 32'h4, 32'h0, rd, k, e);
    n_tests++;
    if (rd !== 32'h2 || k !== 1'b1 || e !== 1'b0) begin
      n_fail++; $display("FAIL reset_status: got dat=%h ack=%b err=%b expected 00000002/1/0", rd, k, e);
    end
    xfer(1'b0, 32'h0, 32'h0, rd, k, e);
    n_tests++;
    if (rd !== 32'h0 || k !== 1'b0 || e !== 1'b1) begin
      n_fail++; $display("FAIL read_data_err: got dat=%h ack=%b err=%b expected 00000000/0/1", rd, k, e);
    end
  endtask

  task automatic test_msb_first();
    logic [31:0] rd; logic k, e; int e0;
    xfer(1'b1, 32'hC, 32'h0, rd, k, e);
    xfer(1'b1, 32'h8, 32'h1, rd, k, e);
    clear_mon();
    xfer(1'b1, 32'h0, 32'h155, rd, k, e);
    e0 = cyc_cnt;
    repeat (35) @(posedge clk);
    #3;
    n_tests++;
    if (bits_q.size() != 27 || word_at(0, 1) !== 27'h155) begin
      n_fail++; $display("FAIL msb_word: got %0d bits %h expected 27 bits 0000155", bits_q.size(), word_at(0, 1));
    end
    n_tests++;
    if (fcyc_q.size() != 1 || vcyc_q.size() != 27 || fcyc_q[0] != e0 + 1) begin
      n_fail++; $display("FAIL msb_frame: got %0d frame bits expected 1 at first bit", fcyc_q.size());
    end
    n_tests++;
    if (vcyc_q.size() != 27 || vcyc_q[0] != e0 + 1 || vcyc_q[26] != e0 + 27) begin
      n_fail++; $display("FAIL msb_latency: got %0d valid bits expected 27 in cycles E0+1..E0+27", vcyc_q.size());
    end
    n_tests++;
    if ({sbusy, svalid, sdata} !== 3'b0) begin
      n_fail++; $display("FAIL msb_idle: got busy/valid/data %b expected 000", {sbusy, svalid, sdata});
    end
  endtask

  task automatic test_lsb_first();
    logic [31:0] rd; logic k, e; int hold_bad;
    xfer(1'b1, 32'hC, 32'h3, rd, k, e);
    xfer(1'b1, 32'h8, 32'h3, rd, k, e);
    clear_mon();
    xfer(1'b1, 32'h0, 32'h155, rd, k, e);
    repeat (120) @(posedge clk);
    #3;
    hold_bad = 0;
    for (int i = 0; i < bits_q.size(); i++)
      if (bits_q[i] !== bits_q[i - (i % 4)]) hold_bad++;
    n_tests++;
    if (bits_q.size() != 108 || hold_bad != 0) begin
      n_fail++; $display("FAIL lsb_timing: got %0d valid cycles, %0d unstable expected 108, 0", bits_q.size(), hold_bad);
    end
    n_tests++;
    if (word_at(0, 4) !== 27'h5540000) begin
      n_fail++; $display("FAIL lsb_word: got %h expected 5540000", word_at(0, 4));
    end
  endtask

  task automatic test_fifo_full();
    logic [31:0] rd; logic k, e; int bad;
    logic [26:0] exp_w [5];
    exp_w[0] = 27'h1234567; exp_w[1] = 27'h2ABCDEF; exp_w[2] = 27'h5555555;
    exp_w[3] = 27'h0F0F0F0; exp_w[4] = 27'h3C3C3C3;
    xfer(1'b1, 32'h8, 32'h0, rd, k, e);
    xfer(1'b1, 32'hC, 32'h0, rd, k, e);
    for (int i = 0; i < 4; i++) xfer(1'b1, 32'h0, 32'(exp_w[i]), rd, k, e);
    xfer(1'b1, 32'h0, 32'h7000001, rd, k, e);
    n_tests++;
    if (k !== 1'b1 || e !== 1'b0) begin
      n_fail++; $display("FAIL ovf_ack: got ack=%b err=%b expected 1/0", k, e);
    end
    xfer(1'b0, 32'h4, 32'h0, rd, k, e);
    n_tests++;
    if (rd !== 32'h040C) begin
      n_fail++; $display("FAIL full_status: got %h expected 0000040c", rd);
    end
    xfer(1'b1, 32'h4, 32'h8, rd, k, e);
    xfer(1'b0, 32'h4, 32'h0, rd, k, e);
    n_tests++;
    if (rd !== 32'h0404) begin
      n_fail++; $display("FAIL ovf_clear: got %h expected 00000404", rd);
    end
    clear_mon();
    xfer(1'b1, 32'h8, 32'h1, rd, k, e);
    xfer(1'b1, 32'h0, 32'(exp_w[4]), rd, k, e);
    xfer(1'b0, 32'h4, 32'h0, rd, k, e);
    n_tests++;
    if (rd !== 32'h0405) begin
      n_fail++; $display("FAIL push_pop_full: got %h expected 00000405", rd);
    end
    repeat (150) @(posedge clk);
    #3;
    n_tests++;
    if (bits_q.size() != 135 || vcyc_q[134] - vcyc_q[0] != 134) begin
      n_fail++; $display("FAIL b2b_gap: got %0d valid bits expected 135 contiguous", bits_q.size());
    end
    bad = 0;
    for (int i = 1; i < fcyc_q.size(); i++) if (fcyc_q[i] - fcyc_q[i-1] != 27) bad++;
    n_tests++;
    if (fcyc_q.size() != 5 || bad != 0) begin
      n_fail++; $display("FAIL b2b_frame: got %0d frames, %0d misspaced expected 5, 0", fcyc_q.size(), bad);
    end
    for (int i = 0; i < 5; i++) begin
      n_tests++;
      if (word_at(27 * i, 1) !== exp_w[i]) begin
        n_fail++; $display("FAIL b2b_word%0d: got %h expected %h", i, word_at(27 * i, 1), exp_w[i]);
      end
    end
    xfer(1'b0, 32'h4, 32'h0, rd, k, e);
    n_tests++;
    if (rd !== 32'h0002) begin
      n_fail++; $display("FAIL drained_status: got %h expected 00000002", rd);
    end
  endtask

  task automatic test_clr();
    logic [31:0] rd; logic k, e;
    clear_mon();
    xfer(1'b1, 32'h0, 32'h7FFFFFF, rd, k, e);
    xfer(1'b1, 32'h0, 32'h7FFFFFF, rd, k, e);
    repeat (9) @(posedge clk);
    #1;
    n_tests++;
    if ({svalid, sdata} !== 2'b11) begin
      n_fail++; $display("FAIL clr_pre: got valid/data %b expected 11", {svalid, sdata});
    end
    xfer(1'b1, 32'h8, 32'h5, rd, k, e);
    n_tests++;
    if ({svalid, sdata, sframe, sbusy} !== 4'b0) begin
      n_fail++; $display("FAIL clr_abort: got valid/data/frame/busy %b expected 0000", {svalid, sdata, sframe, sbusy});
    end
    xfer(1'b0, 32'h4, 32'h0, rd, k, e);
    n_tests++;
    if (rd !== 32'h0002 || bits_q.size() != 10) begin
      n_fail++; $display("FAIL clr_flush: got status %h, %0d bits expected 00000002, 10", rd, bits_q.size());
    end
  endtask

  task automatic test_async_reset();
    logic [31:0] rd; logic k, e;
    xfer(1'b1, 32'hC, 32'h5, rd, k, e);
    xfer(1'b1, 32'h0, 32'h7FFFFFF, rd, k, e);
    repeat (8) @(posedge clk);
    @(negedge clk);
    #2;
    n_tests++;
    if ({svalid, sdata, sbusy} !== 3'b111) begin
      n_fail++; $display("FAIL arst_pre: got valid/data/busy %b expected 111", {svalid, sdata, sbusy});
    end
    rst = 1'b1;
    #1;
    n_tests++;
    if ({sdata, svalid, sframe, sbusy, sirq} !== 5'b0) begin
      n_fail++; $display("FAIL arst_outputs: got %b expected 00000", {sdata, svalid, sframe, sbusy, sirq});
    end
    @(negedge clk);
    rst = 1'b0;
    xfer(1'b0, 32'h8, 32'h0, rd, k, e);
    n_tests++;
    if (rd !== 32'h0) begin
      n_fail++; $display("FAIL arst_ctrl: got %h expected 00000000", rd);
    end
    xfer(1'b0, 32'hC, 32'h0, rd, k, e);
    n_tests++;
    if (rd !== 32'h0) begin
      n_fail++; $display("FAIL arst_div: got %h expected 00000000", rd);
    end
  endtask

  task automatic test_regs_irq();
    logic [31:0] rd; logic k, e;
    xfer(1'b1, 32'hC, 32'hA5, rd, k, e);
    xfer(1'b0, 32'hC, 32'h0, rd, k, e);
    n_tests++;
    if (rd !== 32'hA5) begin
      n_fail++; $display("FAIL div_rw: got %h expected 000000a5", rd);
    end
    xfer(1'b1, 32'hC, 32'h0, rd, k, e);
    xfer(1'b1, 32'h8, 32'hD, rd, k, e);
    n_tests++;
    if (rd !== 32'h0 || k !== 1'b1) begin
      n_fail++; $display("FAIL write_dat_o: got dat=%h ack=%b expected 00000000/1", rd, k);
    end
    xfer(1'b0, 32'h8, 32'h0, rd, k, e);
    n_tests++;
    if (rd !== 32'h9) begin
      n_fail++; $display("FAIL ctrl_read: got %h expected 00000009", rd);
    end
    n_tests++;
    if (sirq !== 1'b1) begin
      n_fail++; $display("FAIL irq_idle: got %b expected 1", sirq);
    end
    xfer(1'b0, 32'h6, 32'h0, rd, k, e);
    n_tests++;
    if (e !== 1'b1 || k !== 1'b0 || rd !== 32'h0) begin
      n_fail++; $display("FAIL err_rd6: got err=%b ack=%b dat=%h expected 1/0/00000000", e, k, rd);
    end
    xfer(1'b1, 32'h6, 32'h1, rd, k, e);
    n_tests++;
    if (e !== 1'b1 || k !== 1'b0) begin
      n_fail++; $display("FAIL err_wr6: got err=%b ack=%b expected 1/0", e, k);
    end
    xfer(1'b1, 32'h0, 32'h1, rd, k, e);
    n_tests++;
    if (sirq !== 1'b0) begin
      n_fail++; $display("FAIL irq_push: got %b expected 0", sirq);
    end
    repeat (15) @(posedge clk);
    #1;
    n_tests++;
    if ({sirq, sbusy} !== 2'b01) begin
      n_fail++; $display("FAIL irq_busy: got irq/busy %b expected 01", {sirq, sbusy});
    end
    repeat (20) @(posedge clk);
    #1;
    n_tests++;
    if ({sirq, sbusy} !== 2'b10) begin
      n_fail++; $display("FAIL irq_done: got irq/busy %b expected 10", {sirq, sbusy});
    end
  endtask

  initial begin
    test_reset();
    test_msb_first();
    test_lsb_first();
    test_fifo_full();
    test_clr();
    test_async_reset();
    test_regs_irq();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
